// File: rtl/vdp_raster_irq.sv
// vdp_raster_irq: vblank/line-compare interrupt unit with host registers; optional repeat via VDP_RASTER_IRQ_REPEAT_EN
module vdp_raster_irq #(
  parameter int V_ACTIVE_HEIGHT   = 480,
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  raster_y,
  input  logic        active_line_started,
  input  logic        active_frame_ended,
  input  logic        frame_ended,
  input  logic        reg_write,
  input  logic        reg_read,
  input  logic [2:0]  reg_address,
  input  logic [15:0] reg_write_data,
  output logic [15:0] reg_read_data,
  output logic        reg_read_valid,
  output logic        irq
);
  localparam logic [10:0] VH = 11'(V_ACTIVE_HEIGHT);
  logic [1:0] ctrl, ctrl_n, pend, pend_n;
  logic [9:0] line_cmp, line_cmp_n, line_step, line_step_n, target, target_n, adv;
  logic in_vb, in_vb_n, dead, dead_n, ovf, match, irq_n;
  logic [FRAME_COUNT_WIDTH-1:0] fc, fc_n;
  logic [15:0] rmux;
  logic wr0, wr1, wr2, wr3, wr4;
  logic unused;
  assign unused = ^reg_write_data[15:10];
`ifdef VDP_RASTER_IRQ_REPEAT_EN
  logic [10:0] sum;
  // advance the compare target by LINE_STEP after each match; a carry out kills matching for the frame
  always_comb begin
    sum = {1'b0, target} + {1'b0, line_step};
    line_step_n = wr4 ? reg_write_data[9:0] : line_step;
    adv = (match && line_step != 10'd0) ? sum[9:0] : target;
    ovf = match & sum[10];
  end
`else
  // no repeat: LINE_STEP is fixed at zero and the target only moves on reload
  always_comb begin
    line_step_n = 10'd0;
    adv = target;
    ovf = 1'b0;
  end
`endif
  // next-state for registers, events and read mux
  always_comb begin
    wr0 = reg_write && reg_address == 3'd0;
    wr1 = reg_write && reg_address == 3'd1;
    wr2 = reg_write && reg_address == 3'd2;
    wr3 = reg_write && reg_address == 3'd3;
    wr4 = reg_write && reg_address == 3'd4;
    match = active_line_started && raster_y == target && {1'b0, target} < VH && !dead;
    ctrl_n = wr0 ? reg_write_data[1:0] : ctrl;
    line_cmp_n = wr1 ? reg_write_data[9:0] : line_cmp;
    pend_n = (pend & ~(wr2 ? reg_write_data[1:0] : 2'b00)) | {match & ctrl[1], active_frame_ended & ctrl[0]};
    in_vb_n = active_frame_ended | (in_vb & ~frame_ended);
    fc_n = wr3 ? '0 : frame_ended ? fc + 1'b1 : fc;
    target_n = wr1 ? reg_write_data[9:0] : frame_ended ? line_cmp : adv;
    dead_n = (wr1 || frame_ended) ? 1'b0 : dead | ovf;
    irq_n = |(pend_n & ctrl_n);
    rmux = reg_address == 3'd0 ? {14'd0, ctrl} :
           reg_address == 3'd1 ? {6'd0, line_cmp} :
           reg_address == 3'd2 ? {13'd0, in_vb, pend} :
           reg_address == 3'd3 ? 16'(fc) :
           reg_address == 3'd4 ? {6'd0, line_step} : 16'd0;
  end
  // state, irq and registered read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
      line_cmp <= '0;
      line_step <= '0;
      target <= '0;
      dead <= 1'b0;
      pend <= '0;
      in_vb <= 1'b0;
      fc <= '0;
      irq <= 1'b0;
      reg_read_data <= '0;
      reg_read_valid <= 1'b0;
    end else begin
      ctrl <= ctrl_n;
      line_cmp <= line_cmp_n;
      line_step <= line_step_n;
      target <= target_n;
      dead <= dead_n;
      pend <= pend_n;
      in_vb <= in_vb_n;
      fc <= fc_n;
      irq <= irq_n;
      reg_read_data <= reg_read ? rmux : reg_read_data;
      reg_read_valid <= reg_read;
    end
  end
endmodule
